// File: rtl/fpnew_rob_issue_if.sv
// rtl/fpnew_rob_issue_if.sv - request, FPU and response signal bundle for the ROB issue front end
interface fpnew_rob_issue_if #(
    parameter int FLEN         = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int CTRL_W       = 16,
    parameter int TAG_W        = 4
);
    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [NUM_OPERANDS*FLEN-1:0] req_operands_i;
    logic [CTRL_W-1:0]            req_ctrl_i;

    logic                         fpu_in_valid_o;
    logic                         fpu_in_ready_i;
    logic [NUM_OPERANDS*FLEN-1:0] fpu_operands_o;
    logic [CTRL_W-1:0]            fpu_ctrl_o;
    logic [TAG_W-1:0]             fpu_tag_o;

    logic                         fpu_out_valid_i;
    logic                         fpu_out_ready_o;
    logic [FLEN-1:0]              fpu_result_i;
    logic [4:0]                   fpu_status_i;
    logic [TAG_W-1:0]             fpu_tag_i;
    logic                         fpu_busy_i;

    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [FLEN-1:0]              rsp_result_o;
    logic [4:0]                   rsp_status_o;

    // Environment side: the requesting core plus the FPU wrapper
    modport master (
        output req_valid_i, req_operands_i, req_ctrl_i,
        output fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, fpu_busy_i,
        output rsp_ready_i,
        input  req_ready_o, fpu_in_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o,
        input  fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o
    );

    // ROB issue front end side
    modport slave (
        input  req_valid_i, req_operands_i, req_ctrl_i,
        input  fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, fpu_busy_i,
        input  rsp_ready_i,
        output req_ready_o, fpu_in_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o,
        output fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o
    );
endinterface

// File: rtl/fpnew_rob_issue.sv
// rtl/fpnew_rob_issue.sv - in-order issue/retire reorder buffer in front of an fpnew instance
module fpnew_rob_issue #(
    parameter int FLEN         = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int CTRL_W       = 16,
    parameter int DEPTH        = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fpnew_rob_issue_if.slave   bus,
    input  logic               flush_i,
    output logic               fpu_flush_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = IDX_W + 1;
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE   = (IDX_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [IDX_W:0]   count;
    logic             epoch;
    logic [DEPTH-1:0] valid;
    logic [FLEN-1:0]  res_mem [DEPTH];
    logic [4:0]       sts_mem [DEPTH];

    logic             full;
    logic             empty;
    logic             issue_fire;
    logic             rsp_fire;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] cap_idx;
    logic [IDX_W-1:0] cap_off;
    logic             cap_epoch;
    logic             cap_in_flight;
    logic             cap_cur;
    logic             cap_ok;
    logic             cap_err;

    assign count    = tail - head;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (head == tail);
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // Issue path is a straight pass-through gated by ROB space and flush
    assign bus.fpu_in_valid_o = bus.req_valid_i & ~full & ~flush_i;
    assign bus.req_ready_o    = bus.fpu_in_ready_i & ~full & ~flush_i;
    assign bus.fpu_operands_o = bus.req_operands_i;
    assign bus.fpu_ctrl_o     = bus.req_ctrl_i;
    assign bus.fpu_tag_o      = {epoch, tail_idx};
    assign issue_fire         = bus.req_valid_i & bus.req_ready_o;

    assign fpu_flush_o         = flush_i;
    assign bus.fpu_out_ready_o = 1'b1;

    // A returning result is accepted only for a live, still-unfilled slot of the current epoch;
    // stale-epoch results are expected after a flush and are dropped without complaint
    assign cap_idx       = bus.fpu_tag_i[IDX_W-1:0];
    assign cap_epoch     = bus.fpu_tag_i[TAG_W-1];
    assign cap_off       = cap_idx - head_idx;
    assign cap_in_flight = ({1'b0, cap_off} < count);
    assign cap_cur       = bus.fpu_out_valid_i & ~flush_i & (cap_epoch == epoch);
    assign cap_ok        = cap_cur & cap_in_flight & ~valid[cap_idx];
    assign cap_err       = cap_cur & ~(cap_in_flight & ~valid[cap_idx]);

    // Retire strictly from the head; no bypass from the capture port
    assign bus.rsp_valid_o  = valid[head_idx] & ~empty & ~flush_i;
    assign bus.rsp_result_o = res_mem[head_idx];
    assign bus.rsp_status_o = sts_mem[head_idx];
    assign rsp_fire         = bus.rsp_valid_o & bus.rsp_ready_i;

    assign busy_o = ~empty | bus.fpu_busy_i;

    // Pointer, epoch and sticky error state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            epoch <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (cap_err) begin
                err_o <= 1'b1;
            end
            if (flush_i) begin
                head  <= tail;
                epoch <= ~epoch;
            end else begin
                if (issue_fire) begin
                    tail <= tail + PTR_ONE;
                end
                if (rsp_fire) begin
                    head <= head + PTR_ONE;
                end
            end
        end
    end

    // Per-slot result-present bits: reserve on issue, set on capture, clear on retire
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else begin
            if (issue_fire) begin
                valid[tail_idx] <= 1'b0;
            end
            if (rsp_fire) begin
                valid[head_idx] <= 1'b0;
            end
            if (cap_ok) begin
                valid[cap_idx] <= 1'b1;
            end
        end
    end

    // Result payload storage; only written into unfilled slots so the head stays stable
    always_ff @(posedge clk_i) begin
        if (cap_ok) begin
            res_mem[cap_idx] <= bus.fpu_result_i;
            sts_mem[cap_idx] <= bus.fpu_status_i;
        end
    end
endmodule

// File: tb/tb_fpnew_rob_issue.sv
// tb/tb_fpnew_rob_issue.sv - scoreboard bench for the fpnew ROB issue front end
module tb_fpnew_rob_issue;
    localparam int FLEN   = 64;
    localparam int NOPS   = 3;
    localparam int CTRL_W = 16;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [FLEN-1:0]  res;
        logic [4:0]       st;
        int               due;
    } fpu_op_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic fpu_flush;
    logic busy;
    logic err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_count = 0;
    bit auto_fpu = 0;
    logic last_rsp_busy;

    fpu_op_t          pipe[$];
    logic [68:0]      sb[$];
    int               rsp_cycles[$];
    logic [TAG_W-1:0] issued_tags[$];

    fpnew_rob_issue_if #(.FLEN(FLEN), .NUM_OPERANDS(NOPS), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) bus ();

    fpnew_rob_issue #(.FLEN(FLEN), .NUM_OPERANDS(NOPS), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus.slave),
        .flush_i     (flush),
        .fpu_flush_o (fpu_flush),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Reference FPU: result = a + b, status = c[4:0]
    function automatic logic [68:0] model(input logic [NOPS*FLEN-1:0] ops);
        return {ops[132:128], ops[63:0] + ops[127:64]};
    endfunction

    function automatic logic [NOPS*FLEN-1:0] rand_ops();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_operands_i = '0;
        bus.req_ctrl_i = 16'h00a5;
        bus.fpu_in_ready_i = 1'b1;
        bus.fpu_out_valid_i = 1'b0;
        bus.fpu_result_i = '0;
        bus.fpu_status_i = '0;
        bus.fpu_tag_i = '0;
        bus.fpu_busy_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        pipe.delete();
        sb.delete();
        rsp_cycles.delete();
        issued_tags.delete();
        rsp_count = 0;
    endtask

    // One clock cycle: present FPU output, record issue/retire fires, score responses
    task automatic step();
        bit popped = 0;
        logic [68:0] m;
        logic [68:0] e;
        fpu_op_t p;
        if (auto_fpu) begin
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                bus.fpu_out_valid_i = 1'b1;
                bus.fpu_tag_i = pipe[0].tag;
                bus.fpu_result_i = pipe[0].res;
                bus.fpu_status_i = pipe[0].st;
                popped = 1;
            end else begin
                bus.fpu_out_valid_i = 1'b0;
            end
        end
        #1;
        if (bus.req_valid_i && bus.req_ready_o) begin
            m = model(bus.req_operands_i);
            sb.push_back(m);
            issued_tags.push_back(bus.fpu_tag_o);
            if (auto_fpu) begin
                p.tag = bus.fpu_tag_o;
                p.res = m[63:0];
                p.st = m[68:64];
                p.due = cyc + 3;
                pipe.push_back(p);
            end
        end
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            total++;
            last_rsp_busy = busy;
            rsp_cycles.push_back(cyc);
            rsp_count++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got=%h want=none", {bus.rsp_status_o, bus.rsp_result_o});
            end else begin
                e = sb.pop_front();
                if ({bus.rsp_status_o, bus.rsp_result_o} !== e) begin
                    bad++;
                    $display("FAIL rsp_data got=%h want=%h", {bus.rsp_status_o, bus.rsp_result_o}, e);
                end
            end
        end
        @(posedge clk);
        if (popped) void'(pipe.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid_o); end
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (bus.fpu_tag_o !== 4'd0) begin bad++; $display("FAIL reset_tag got=%h want=0", bus.fpu_tag_o); end
        total++; if (bus.fpu_out_ready_o !== 1'b1) begin bad++; $display("FAIL out_ready got=%b want=1", bus.fpu_out_ready_o); end
        bus.fpu_in_ready_i = 1'b0;
        #1;
        total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready_follow got=%b want=0", bus.req_ready_o); end
        bus.fpu_busy_i = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_follow got=%b want=1", busy); end
        bus.fpu_in_ready_i = 1'b1;
        bus.fpu_busy_i = 1'b0;
    endtask

    task automatic test_in_order();
        int c0;
        do_reset();
        auto_fpu = 1;
        bus.rsp_ready_i = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = rand_ops();
            step();
        end
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 40 && rsp_count < 4; n++) step();
        total++; if (rsp_count !== 4) begin bad++; $display("FAIL inorder_count got=%0d want=4", rsp_count); end
        total++; if (issued_tags.size() !== 4) begin bad++; $display("FAIL inorder_issued got=%0d want=4", issued_tags.size()); end
        for (int i = 0; i < 4 && i < issued_tags.size(); i++) begin
            total++;
            if (issued_tags[i] !== TAG_W'(i)) begin bad++; $display("FAIL inorder_tag%0d got=%h want=%h", i, issued_tags[i], i); end
        end
        for (int i = 0; i < 4 && i < rsp_cycles.size(); i++) begin
            total++;
            if (rsp_cycles[i] !== c0 + 4 + i) begin bad++; $display("FAIL inorder_rsp_cycle%0d got=%0d want=%0d", i, rsp_cycles[i], c0 + 4 + i); end
        end
        #1;
        total++; if (last_rsp_busy !== 1'b1) begin bad++; $display("FAIL inorder_busy_at_last got=%b want=1", last_rsp_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL inorder_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_out_of_order();
        logic [NOPS*FLEN-1:0] ops [3];
        logic [68:0] m [3];
        do_reset();
        auto_fpu = 0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ops[i] = rand_ops();
            m[i] = model(ops[i]);
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = ops[i];
            step();
        end
        bus.req_valid_i = 1'b0;
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_tag_i = 4'd2;
        {bus.fpu_status_i, bus.fpu_result_i} = m[2];
        step();
        bus.fpu_tag_i = 4'd0;
        {bus.fpu_status_i, bus.fpu_result_i} = m[0];
        #1;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_hold got=%b want=0", bus.rsp_valid_o); end
        step();
        bus.fpu_tag_i = 4'd1;
        {bus.fpu_status_i, bus.fpu_result_i} = m[1];
        #1;
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL ooo_first_rsp got=%b want=1", bus.rsp_valid_o); end
        total++; if (bus.rsp_result_o !== m[0][63:0]) begin bad++; $display("FAIL ooo_first_data got=%h want=%h", bus.rsp_result_o, m[0][63:0]); end
        step();
        bus.fpu_out_valid_i = 1'b0;
        for (int n = 0; n < 20 && rsp_count < 3; n++) step();
        total++; if (rsp_count !== 3) begin bad++; $display("FAIL ooo_count got=%0d want=3", rsp_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ooo_err got=%b want=0", err); end
    endtask

    task automatic test_backpressure_full();
        logic [FLEN-1:0] held;
        do_reset();
        auto_fpu = 1;
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = rand_ops();
            #1;
            total++;
            if (bus.req_ready_o !== (i < 8)) begin bad++; $display("FAIL full_ready%0d got=%b want=%b", i, bus.req_ready_o, (i < 8)); end
            step();
        end
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 4; n++) step();
        #1;
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL full_rsp_valid got=%b want=1", bus.rsp_valid_o); end
        held = bus.rsp_result_o;
        step();
        #1;
        total++; if (bus.rsp_result_o !== held) begin bad++; $display("FAIL full_rsp_stable got=%h want=%h", bus.rsp_result_o, held); end
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_operands_i = rand_ops();
        #1;
        total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready_retire_cycle got=%b want=0", bus.req_ready_o); end
        step();
        #1;
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b want=1", bus.req_ready_o); end
        total++; if (bus.fpu_tag_o !== 4'd0) begin bad++; $display("FAIL full_tag_wrap got=%h want=0", bus.fpu_tag_o); end
        step();
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 40 && rsp_count < 9; n++) step();
        total++; if (rsp_count !== 9) begin bad++; $display("FAIL full_count got=%0d want=9", rsp_count); end
        total++; if (issued_tags.size() !== 9) begin bad++; $display("FAIL full_issued got=%0d want=9", issued_tags.size()); end
        if (issued_tags.size() == 9) begin
            total++; if (issued_tags[7] !== 4'd7) begin bad++; $display("FAIL full_tag7 got=%h want=7", issued_tags[7]); end
            total++; if (issued_tags[8] !== 4'd0) begin bad++; $display("FAIL full_tag8 got=%h want=0", issued_tags[8]); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        auto_fpu = 1;
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = rand_ops();
            step();
        end
        bus.req_valid_i = 1'b0;
        step();
        bus.rsp_ready_i = 1'b1;
        #1;
        total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL flush_pre_rsp got=%b want=1", bus.rsp_valid_o); end
        flush = 1'b1;
        bus.req_valid_i = 1'b1;
        #1;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_rsp_forced got=%b want=0", bus.rsp_valid_o); end
        total++; if (fpu_flush !== 1'b1) begin bad++; $display("FAIL flush_fpu_flush got=%b want=1", fpu_flush); end
        total++; if (bus.fpu_in_valid_o !== 1'b0) begin bad++; $display("FAIL flush_in_valid got=%b want=0", bus.fpu_in_valid_o); end
        sb.delete();
        step();
        flush = 1'b0;
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 6; n++) step();
        total++; if (rsp_count !== 0) begin bad++; $display("FAIL flush_no_rsp got=%0d want=0", rsp_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL flush_err got=%b want=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        bus.req_valid_i = 1'b1;
        bus.req_operands_i = rand_ops();
        #1;
        total++; if (bus.fpu_tag_o !== 4'b1011) begin bad++; $display("FAIL flush_new_tag got=%h want=b", bus.fpu_tag_o); end
        step();
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 20 && rsp_count < 1; n++) step();
        total++; if (rsp_count !== 1) begin bad++; $display("FAIL flush_post_rsp got=%0d want=1", rsp_count); end
    endtask

    task automatic test_protocol_error();
        do_reset();
        auto_fpu = 0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = rand_ops();
            step();
        end
        bus.req_valid_i = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL perr_pre got=%b want=0", err); end
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_tag_i = 4'd5;
        bus.fpu_result_i = 64'hdead_beef_0000_0005;
        bus.fpu_status_i = 5'h1f;
        step();
        bus.fpu_out_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (err !== 1'b1) begin bad++; $display("FAIL perr_err%0d got=%b want=1", k, err); end
            total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL perr_rsp%0d got=%b want=0", k, bus.rsp_valid_o); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_fpu = 1;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_operands_i = rand_ops();
            step();
        end
        do_reset();
        bus.rsp_ready_i = 1'b1;
        #1;
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_rsp got=%b want=0", bus.rsp_valid_o); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", err); end
        bus.req_valid_i = 1'b1;
        bus.req_operands_i = rand_ops();
        #1;
        total++; if (bus.fpu_tag_o !== 4'd0) begin bad++; $display("FAIL rmid_tag got=%h want=0", bus.fpu_tag_o); end
        step();
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 20 && rsp_count < 1; n++) step();
        total++; if (rsp_count !== 1) begin bad++; $display("FAIL rmid_rsp_count got=%0d want=1", rsp_count); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_backpressure_full();
        test_flush();
        test_protocol_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
